// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted two-input integration, periodic shift leak, refractory hold.
// Optional saturating fire counter on spike_count when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron #(
  parameter int WIDTH          = 8,
  parameter int WEIGHT_A       = 20,
  parameter int WEIGHT_B       = 12,
  parameter int THRESHOLD      = 100,
  parameter int LEAK_PERIOD    = 4,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 5,
  parameter int CNT_WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in_a,
  input  logic             spike_in_b,
  output logic             spike,
  output logic [WIDTH-1:0] membrane,
  output logic             refractory
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] spike_count
`endif
);

  typedef enum logic {ST_INTEGRATE, ST_REFRACT} state_t;

  localparam int VW  = WIDTH + 2;
  localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RCW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [VW-1:0]    V_MAX   = {2'b00, {WIDTH{1'b1}}};
  localparam logic [VW-1:0]    WA      = VW'(WEIGHT_A);
  localparam logic [VW-1:0]    WB      = VW'(WEIGHT_B);
  localparam logic [WIDTH-1:0] TH      = WIDTH'(THRESHOLD);
  localparam logic [LCW-1:0]   LC_LAST = LCW'(LEAK_PERIOD - 1);
  localparam logic [RCW-1:0]   RC_INIT = RCW'(REFRACT_CYCLES);
  localparam logic [RCW-1:0]   RC_ONE  = RCW'(1);

  state_t           state;
  logic [LCW-1:0]   leak_cnt;
  logic [RCW-1:0]   refract_cnt;

  logic [WIDTH-1:0] leak;
  logic [VW-1:0]    v_raw;
  logic [WIDTH-1:0] v_next;
  logic [LCW-1:0]   leak_cnt_nxt;
  logic             fire;

  // Two guard bits keep the sum exact before saturation; leak <= membrane so no underflow.
  always_comb begin
    leak         = (leak_cnt == LC_LAST) ? (membrane >> LEAK_SHIFT) : '0;
    v_raw        = {2'b00, membrane} - {2'b00, leak}
                 + (spike_in_a ? WA : '0) + (spike_in_b ? WB : '0);
    v_next       = (v_raw > V_MAX) ? {WIDTH{1'b1}} : v_raw[WIDTH-1:0];
    fire         = (v_next >= TH);
    leak_cnt_nxt = (leak_cnt == LC_LAST) ? '0 : leak_cnt + LCW'(1);
  end

  assign refractory = (state == ST_REFRACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INTEGRATE;
      membrane    <= '0;
      spike       <= 1'b0;
      leak_cnt    <= '0;
      refract_cnt <= '0;
    end else begin
      spike <= 1'b0;
      if (enable) begin
        case (state)
          ST_INTEGRATE: begin
            if (fire) begin
              spike    <= 1'b1;
              membrane <= '0;
              leak_cnt <= '0;
              if (REFRACT_CYCLES > 0) begin
                state       <= ST_REFRACT;
                refract_cnt <= RC_INIT;
              end
            end else begin
              membrane <= v_next;
              leak_cnt <= leak_cnt_nxt;
            end
          end
          ST_REFRACT: begin
            membrane    <= '0;
            refract_cnt <= refract_cnt - RC_ONE;
            if (refract_cnt == RC_ONE) state <= ST_INTEGRATE;
          end
          default: state <= ST_INTEGRATE;
        endcase
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      spike_count <= '0;
    else if (enable && state == ST_INTEGRATE && fire && spike_count != {CNT_WIDTH{1'b1}})
      spike_count <= spike_count + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: spec vector table, hand-written corner sequences, random vs behavioural model.
module tb_lif_neuron;

  localparam int WIDTH = 8, WA = 20, WB = 12, TH = 100, LP = 4, LS = 3, RC = 5;

  logic       clk = 1'b0;
  logic       reset, enable, spike_in_a, spike_in_b;
  logic       spike, refractory;
  logic [7:0] membrane;
`ifdef LIF_SPIKE_COUNT_EN
  logic [1:0] spike_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lif_neuron #(
    .WIDTH(WIDTH), .WEIGHT_A(WA), .WEIGHT_B(WB), .THRESHOLD(TH),
    .LEAK_PERIOD(LP), .LEAK_SHIFT(LS), .REFRACT_CYCLES(RC), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spike_in_a(spike_in_a), .spike_in_b(spike_in_b),
    .spike(spike), .membrane(membrane), .refractory(refractory)
`ifdef LIF_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  typedef struct {
    bit    rst, en, a, b;
    int    e_spike, e_mem, e_refr;
    string tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, en, a, b, input int es, em, er, input string tag);
    vec_t v;
    v.rst = rst; v.en = en; v.a = a; v.b = b;
    v.e_spike = es; v.e_mem = em; v.e_refr = er; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int es, input int em, input int er);
    check({name, ".spike"}, int'(spike), es);
    check({name, ".membrane"}, int'(membrane), em);
    check({name, ".refractory"}, int'(refractory), er);
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic tick(input bit rst, en, a, b);
    reset = rst; enable = en; spike_in_a = a; spike_in_b = b;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: remaining refractory cycles, leak phase, potential as plain ints.
  int m_mem, m_phase, m_refr_left, m_spike;

  task automatic model_step(input bit rst, en, a, b);
    int v;
    if (rst) begin
      m_mem = 0; m_phase = 0; m_refr_left = 0; m_spike = 0;
    end else if (!en) begin
      m_spike = 0;
    end else if (m_refr_left > 0) begin
      m_refr_left--; m_mem = 0; m_spike = 0;
    end else begin
      v = m_mem - ((m_phase == LP - 1) ? (m_mem >> LS) : 0) + (a ? WA : 0) + (b ? WB : 0);
      if (v > 255) v = 255;
      m_phase = (m_phase + 1) % LP;
      if (v >= TH) begin
        m_spike = 1; m_mem = 0; m_phase = 0; m_refr_left = RC;
      end else begin
        m_mem = v; m_spike = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; spike_in_a = 1'b0; spike_in_b = 1'b0;

    // Single input every cycle: leak at edge 4, fire at edge 6, 5 refractory cycles.
    add(1,0,0,0, 0,0,0,  "rst0");
    add(0,1,1,0, 0,20,0, "a.e1");
    add(0,1,1,0, 0,40,0, "a.e2");
    add(0,1,1,0, 0,60,0, "a.e3");
    add(0,1,1,0, 0,73,0, "a.e4");
    add(0,1,1,0, 0,93,0, "a.e5");
    add(0,1,1,0, 1,0,1,  "a.e6");
    add(0,1,1,0, 0,0,1,  "a.e7");
    add(0,1,1,0, 0,0,1,  "a.e8");
    add(0,1,1,0, 0,0,1,  "a.e9");
    add(0,1,1,0, 0,0,1,  "a.e10");
    add(0,1,1,0, 0,0,0,  "a.e11");
    add(0,1,1,0, 0,20,0, "a.e12");
    // Dual input same cycle.
    add(1,0,0,0, 0,0,0,  "rst1");
    add(0,1,1,1, 0,32,0, "ab.e1");
    add(0,1,1,1, 0,64,0, "ab.e2");
    add(0,1,1,1, 0,96,0, "ab.e3");
    add(0,1,1,1, 1,0,1,  "ab.e4");
    // Three spikes then idle: leak-only decay.
    add(1,0,0,0, 0,0,0,  "rst2");
    add(0,1,1,0, 0,20,0, "idle.e1");
    add(0,1,1,0, 0,40,0, "idle.e2");
    add(0,1,1,0, 0,60,0, "idle.e3");
    add(0,1,0,0, 0,53,0, "idle.e4");
    add(0,1,0,0, 0,53,0, "idle.e5");
    add(0,1,0,0, 0,53,0, "idle.e6");
    add(0,1,0,0, 0,53,0, "idle.e7");
    add(0,1,0,0, 0,47,0, "idle.e8");
    add(0,1,0,0, 0,47,0, "idle.e9");
    add(0,1,0,0, 0,47,0, "idle.e10");
    add(0,1,0,0, 0,47,0, "idle.e11");

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].b);
      check_all(vecs[i].tag, vecs[i].e_spike, vecs[i].e_mem, vecs[i].e_refr);
    end

    // Enable low holds state and leak phase while inputs toggle.
    tick(1,0,0,0);
    for (int i = 0; i < 3; i++) tick(0,1,1,0);
    check("hold.pre", int'(membrane), 60);
    for (int i = 0; i < 10; i++) begin
      tick(0,0,1,1);
      check("hold.mem", int'(membrane), 60);
      check("hold.spike", int'(spike), 0);
    end
    tick(0,1,0,0);
    check("hold.leak_resume", int'(membrane), 53);

    // Enable drops right after a fire: pulse still one cycle, refractory retained.
    tick(1,0,0,0);
    for (int i = 0; i < 4; i++) tick(0,1,1,1);
    check("en_drop.fire", int'(spike), 1);
    tick(0,0,1,1);
    check_all("en_drop.after", 0, 0, 1);

    // Reset during third refractory cycle.
    tick(1,0,0,0);
    for (int i = 0; i < 6; i++) tick(0,1,1,0);
    check("rref.fire", int'(spike), 1);
    tick(0,1,1,0);
    tick(0,1,1,0);
    tick(1,1,1,0);
    check_all("rref.reset", 0, 0, 0);
    tick(0,1,1,0);
    check_all("rref.first", 0, 20, 0);

`ifdef LIF_SPIKE_COUNT_EN
    begin
      int fires = 0;
      int exp_cnt[5] = '{1, 2, 3, 3, 3};
      tick(1,0,0,0);
      check("cnt.reset", int'(spike_count), 0);
      for (int i = 0; i < 200 && fires < 5; i++) begin
        tick(0,1,1,0);
        if (spike) begin
          check($sformatf("cnt.fire%0d", fires), int'(spike_count), exp_cnt[fires]);
          fires++;
        end
      end
      check("cnt.fires_seen", fires, 5);
      tick(1,0,0,0);
      check("cnt.reset2", int'(spike_count), 0);
    end
`endif

    // Random stimulus against the behavioural model.
    tick(1,0,0,0);
    model_step(1,0,0,0);
    for (int i = 0; i < 2000; i++) begin
      bit r, e, a, b;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 9) < 8);
      a = $urandom_range(0, 1);
      b = ($urandom_range(0, 2) == 0);
      model_step(r, e, a, b);
      tick(r, e, a, b);
      if (int'(spike) != m_spike || int'(membrane) != m_mem || int'(refractory) != int'(m_refr_left > 0)) begin
        n_fail++;
        $display("FAIL rand[%0d]: got spike=%0d mem=%0d refr=%0d expected spike=%0d mem=%0d refr=%0d",
                 i, spike, membrane, refractory, m_spike, m_mem, int'(m_refr_left > 0));
      end
      n_tests++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron; consumes the single-bit spike outputs of two upstream synapse stages.
- Accumulates weighted input spikes into a membrane potential and leaks it periodically.
- Emits a one-cycle spike on threshold crossing, then enters a refractory period.
- Output spike feeds the next synapse stage of the oscillator network.

Parameters:
WIDTH, 8, membrane potential width in bits
WEIGHT_A, 20, increment applied per spike on spike_in_a
WEIGHT_B, 12, increment applied per spike on spike_in_b
THRESHOLD, 100, firing threshold; legal range 1..2^WIDTH-1
LEAK_PERIOD, 4, enabled integrate cycles between leak events; minimum 1
LEAK_SHIFT, 3, leak amount per leak event is membrane >> LEAK_SHIFT
REFRACT_CYCLES, 5, enabled cycles spent refractory after a spike; 0 means no refractory period
CNT_WIDTH, 8, spike counter width (used only with the optional feature)

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  high = advance; low = hold all state
spike_in_a  input  1  synaptic spike input A
spike_in_b  input  1  synaptic spike input B
spike  output  1  registered one-cycle fire pulse
membrane  output  WIDTH  current membrane potential (registered)
refractory  output  1  high while in the REFRACTORY state
spike_count  output  CNT_WIDTH  total spikes fired (present only with LIF_SPIKE_COUNT_EN)

Behaviour:
- Reset takes priority over enable. On reset:
  - membrane=0, spike=0, refractory=0
  - state=INTEGRATE, leak_cnt=0, refract_cnt=0, spike_count=0
- Reset asserted mid-refractory or mid-integration clears everything on that edge.
- enable=0: all registers hold, except spike, which is registered to 0. Inputs are ignored.
- States: INTEGRATE and REFRACTORY.
- INTEGRATE, each enabled cycle:
  - leak = (leak_cnt == LEAK_PERIOD-1) ? membrane >> LEAK_SHIFT : 0
  - v_next = membrane - leak + (spike_in_a ? WEIGHT_A : 0) + (spike_in_b ? WEIGHT_B : 0)
  - Compute v_next at WIDTH+2 bits and saturate it to 2^WIDTH-1. Subtracting the leak cannot underflow.
  - leak_cnt increments and wraps from LEAK_PERIOD-1 to 0. The leak applies in the same cycle as any inputs.
  - Simultaneous A and B spikes are both added.
  - If v_next >= THRESHOLD:
    - spike<=1, membrane<=0, leak_cnt<=0
    - If REFRACT_CYCLES>0: state<=REFRACTORY and refract_cnt<=REFRACT_CYCLES. Otherwise stay in INTEGRATE.
  - Else membrane<=v_next and spike<=0.
- Latency: an input sampled at edge N that crosses threshold gives spike high after edge N and low after edge N+1.
- REFRACTORY, each enabled cycle:
  - Inputs are ignored; membrane is held at 0; spike<=0.
  - refract_cnt decrements. When refract_cnt==1 at the edge, state<=INTEGRATE.
  - refractory is high for exactly REFRACT_CYCLES enabled cycles.
  - The first input accepted is at the edge after refractory falls.
- The spike pulse is never longer than one cycle, regardless of enable.

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- Defined:
  - spike_count port exists and increments on every edge that sets spike=1.
  - It saturates at 2^CNT_WIDTH-1 (no wrap) and is cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (default parameters):
- spike_in_a=1 every cycle from reset:
  - membrane after edges 1..5 = 20,40,60,73,93 (leak of 7 at edge 4).
  - spike=1 after edge 6 with membrane=0.
  - refractory high after edges 6-10 and low after edge 11.
- spike_in_a=spike_in_b=1 every cycle: membrane 32,64,96, then fire at edge 4 (96-12+32=116). Same-cycle dual input verified.
- spike_in_a for 3 edges, then idle:
  - membrane 20,40,60 then 53 at edge 4.
  - Holds 53 through edge 7, then 47 at edge 8 and 47 held through edge 11. No spike.
- Integrate to 60, then enable=0 for 10 cycles with inputs active: membrane stays 60, spike stays 0, leak phase resumes unchanged.
- Fire, then assert reset during refractory (3rd refractory cycle): next edge gives membrane=0, refractory=0, state INTEGRATE. The next spike_in_a gives membrane=20.
- With LIF_SPIKE_COUNT_EN and CNT_WIDTH=2:
  - Drive continuous spike_in_a for 5 fires. spike_count reads 1,2,3,3,3 (saturates).
  - Reset returns it to 0.
